// File: rtl/matmul_tile_scheduler.sv
// Credit-limited tile walker (reduction innermost); first issue 1 cycle after start, done 1 cycle after last retire.
// Issue fields hold while issue_ready is low; optional perf counters under MATMUL_SCHED_PERF_EN.
module matmul_tile_scheduler #(
  parameter int IDX_WIDTH       = 8,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [IDX_WIDTH-1:0] cfg_n_tiles,
  input  logic [IDX_WIDTH-1:0] cfg_m_tiles,
  input  logic [IDX_WIDTH-1:0] cfg_k_tiles,
  output logic                 issue_valid,
  input  logic                 issue_ready,
  output logic [IDX_WIDTH-1:0] issue_row,
  output logic [IDX_WIDTH-1:0] issue_red,
  output logic [IDX_WIDTH-1:0] issue_col,
  output logic                 issue_first,
  output logic                 issue_last,
  input  logic                 retire_valid,
  output logic                 retire_ready,
  output logic                 done_valid,
  input  logic                 done_ready,
  output logic                 busy,
  output logic                 err_retire,
  output logic [31:0]          perf_cycles,
  output logic [31:0]          perf_stalls
);
  localparam int OUTS_WIDTH = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUTS_WIDTH-1:0] OUTS_MAX = OUTS_WIDTH'(MAX_OUTSTANDING);
  localparam logic [OUTS_WIDTH-1:0] OUTS_ONE = OUTS_WIDTH'(1);
  localparam logic [IDX_WIDTH-1:0]  IDX_ONE  = IDX_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [IDX_WIDTH-1:0]  n_last_q, n_last_d, m_last_q, m_last_d, k_last_q, k_last_d;
  logic [IDX_WIDTH-1:0]  row_q, row_d, red_q, red_d, col_q, col_d;
  logic [OUTS_WIDTH-1:0] outs_q, outs_d;
  logic                  issue_valid_q, issue_valid_d;
  logic                  issue_first_q, issue_first_d;
  logic                  issue_last_q, issue_last_d;
  logic                  done_valid_q, done_valid_d;
  logic                  start_ready_q, start_ready_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic                  start_hs, issue_hs;

  assign start_hs = start_valid && start_ready_q;
  assign issue_hs = issue_valid_q && issue_ready;

  always_comb begin
    state_d  = state_q;
    n_last_d = n_last_q;
    m_last_d = m_last_q;
    k_last_d = k_last_q;
    row_d    = row_q;
    red_d    = red_q;
    col_d    = col_q;
    outs_d   = outs_q;
    err_d    = err_q;

    // A retire with nothing in flight is spurious; a same-cycle issue cancels it out.
    case ({issue_hs, retire_valid})
      2'b10:   outs_d = outs_q + OUTS_ONE;
      2'b01: begin
        if (outs_q == '0) err_d = 1'b1;
        else              outs_d = outs_q - OUTS_ONE;
      end
      default: outs_d = outs_q;
    endcase

    case (state_q)
      IDLE: begin
        if (start_hs) begin
          n_last_d = cfg_n_tiles - IDX_ONE;
          m_last_d = cfg_m_tiles - IDX_ONE;
          k_last_d = cfg_k_tiles - IDX_ONE;
          row_d    = '0;
          red_d    = '0;
          col_d    = '0;
          if (cfg_n_tiles == '0 || cfg_m_tiles == '0 || cfg_k_tiles == '0) state_d = DONE;
          else                                                             state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (issue_hs) begin
          if (red_q == m_last_q) begin
            red_d = '0;
            if (col_q == k_last_q) begin
              col_d = '0;
              if (row_q == n_last_q) begin
                row_d   = '0;
                state_d = DRAIN;
              end else begin
                row_d = row_q + IDX_ONE;
              end
            end else begin
              col_d = col_q + IDX_ONE;
            end
          end else begin
            red_d = red_q + IDX_ONE;
          end
        end
      end
      DRAIN: begin
        if (outs_d == '0) state_d = DONE;
      end
      DONE: begin
        if (done_valid_q && done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    issue_valid_d = (state_d == ISSUE) && (outs_d < OUTS_MAX);
    issue_first_d = (state_d == ISSUE) && (red_d == '0);
    issue_last_d  = (state_d == ISSUE) && (red_d == m_last_d);
    done_valid_d  = (state_d == DONE);
    start_ready_d = (state_d == IDLE);
    busy_d        = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      n_last_q      <= '0;
      m_last_q      <= '0;
      k_last_q      <= '0;
      row_q         <= '0;
      red_q         <= '0;
      col_q         <= '0;
      outs_q        <= '0;
      issue_valid_q <= 1'b0;
      issue_first_q <= 1'b0;
      issue_last_q  <= 1'b0;
      done_valid_q  <= 1'b0;
      start_ready_q <= 1'b1;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      n_last_q      <= n_last_d;
      m_last_q      <= m_last_d;
      k_last_q      <= k_last_d;
      row_q         <= row_d;
      red_q         <= red_d;
      col_q         <= col_d;
      outs_q        <= outs_d;
      issue_valid_q <= issue_valid_d;
      issue_first_q <= issue_first_d;
      issue_last_q  <= issue_last_d;
      done_valid_q  <= done_valid_d;
      start_ready_q <= start_ready_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
    end
  end

  assign start_ready  = start_ready_q;
  assign issue_valid  = issue_valid_q;
  assign issue_row    = row_q;
  assign issue_red    = red_q;
  assign issue_col    = col_q;
  assign issue_first  = issue_first_q;
  assign issue_last   = issue_last_q;
  assign retire_ready = 1'b1;
  assign done_valid   = done_valid_q;
  assign busy         = busy_q;
  assign err_retire   = err_q;

`ifdef MATMUL_SCHED_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d, perf_stalls_q, perf_stalls_d;

  // Both counters saturate and freeze once the job leaves ISSUE/DONE.
  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_stalls_d = perf_stalls_q;
    if (start_hs) begin
      perf_cycles_d = '0;
      perf_stalls_d = '0;
    end else begin
      if (busy_q && perf_cycles_q != '1) perf_cycles_d = perf_cycles_q + 32'd1;
      if (state_q == ISSUE && !issue_hs && perf_stalls_q != '1) perf_stalls_d = perf_stalls_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`else
  assign perf_cycles = 32'd0;
  assign perf_stalls = 32'd0;
`endif

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Directed bench for matmul_tile_scheduler: issue order, credit limit, zero dims, backpressure, errors, reset.
module tb_matmul_tile_scheduler;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [7:0] cfg_n_tiles = '0, cfg_m_tiles = '0, cfg_k_tiles = '0;
  logic       issue_valid;
  logic       issue_ready = 1'b0;
  logic [7:0] issue_row, issue_red, issue_col;
  logic       issue_first, issue_last;
  logic       retire_valid = 1'b0;
  logic       retire_ready;
  logic       done_valid;
  logic       done_ready = 1'b0;
  logic       busy, err_retire;
  logic [31:0] perf_cycles, perf_stalls;

  matmul_tile_scheduler #(.IDX_WIDTH(8), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .cfg_n_tiles(cfg_n_tiles), .cfg_m_tiles(cfg_m_tiles), .cfg_k_tiles(cfg_k_tiles),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_row(issue_row), .issue_red(issue_red), .issue_col(issue_col),
    .issue_first(issue_first), .issue_last(issue_last),
    .retire_valid(retire_valid), .retire_ready(retire_ready),
    .done_valid(done_valid), .done_ready(done_ready),
    .busy(busy), .err_retire(err_retire),
    .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] row, red, col;
    logic       first, last;
  } iss_t;

  typedef struct {
    logic [7:0] n, m, k;
    int         max_done_wait;
  } zvec_t;

  int   n_chk = 0;
  int   n_fail = 0;
  iss_t iss_q[$];
  logic auto_ret = 1'b0;
  logic man_retire = 1'b0;
  logic mon_en = 1'b0;
  logic [3:0] pipe = '0;
  int   n_ret = 0;
  int   n_done = 0;
  int   ret_at_done = -1;

  // Sampled on the falling edge: everything seen here lands on the next rising edge.
  always @(negedge clk) begin
    logic hs;
    hs = issue_valid && issue_ready;
    pipe = {pipe[2:0], hs && auto_ret};
    retire_valid = auto_ret ? pipe[3] : man_retire;
    if (mon_en) begin
      if (hs) iss_q.push_back('{issue_row, issue_red, issue_col, issue_first, issue_last});
      if (retire_valid) n_ret++;
      if (done_valid && done_ready) begin
        n_done++;
        ret_at_done = n_ret;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [7:0] n, input logic [7:0] m, input logic [7:0] k);
    cfg_n_tiles = n;
    cfg_m_tiles = m;
    cfg_k_tiles = k;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int c;
    c = 0;
    while (!done_valid && c < budget) begin
      tick();
      c++;
    end
    chk({name, " done within budget"}, done_valid, 1);
  endtask

  task automatic ack_done();
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
  endtask

  task automatic retire_one();
    man_retire = 1'b1;
    tick();
    man_retire = 1'b0;
  endtask

  function automatic logic [31:0] pk(input iss_t e);
    return {6'd0, e.row, e.red, e.col, e.first, e.last};
  endfunction

  task automatic cmp_seq(input string tag, input iss_t exp_tab[], input int n_exp);
    chk({tag, " issue count"}, iss_q.size(), n_exp);
    for (int i = 0; i < n_exp && i < iss_q.size(); i++)
      chk($sformatf("%s issue %0d {row,red,col,first,last}", tag, i), pk(iss_q[i]), pk(exp_tab[i]));
  endtask

  initial begin
    iss_t  basic_tab[];
    iss_t  small_tab[];
    zvec_t zero_tab[3];

    basic_tab = new[12];
    basic_tab[0]  = '{8'd0, 8'd0, 8'd0, 1'b1, 1'b0};
    basic_tab[1]  = '{8'd0, 8'd1, 8'd0, 1'b0, 1'b0};
    basic_tab[2]  = '{8'd0, 8'd2, 8'd0, 1'b0, 1'b1};
    basic_tab[3]  = '{8'd0, 8'd0, 8'd1, 1'b1, 1'b0};
    basic_tab[4]  = '{8'd0, 8'd1, 8'd1, 1'b0, 1'b0};
    basic_tab[5]  = '{8'd0, 8'd2, 8'd1, 1'b0, 1'b1};
    basic_tab[6]  = '{8'd1, 8'd0, 8'd0, 1'b1, 1'b0};
    basic_tab[7]  = '{8'd1, 8'd1, 8'd0, 1'b0, 1'b0};
    basic_tab[8]  = '{8'd1, 8'd2, 8'd0, 1'b0, 1'b1};
    basic_tab[9]  = '{8'd1, 8'd0, 8'd1, 1'b1, 1'b0};
    basic_tab[10] = '{8'd1, 8'd1, 8'd1, 1'b0, 1'b0};
    basic_tab[11] = '{8'd1, 8'd2, 8'd1, 1'b0, 1'b1};
    small_tab = new[2];
    small_tab[0] = '{8'd0, 8'd0, 8'd0, 1'b1, 1'b0};
    small_tab[1] = '{8'd0, 8'd1, 8'd0, 1'b0, 1'b1};
    zero_tab[0] = '{8'd2, 8'd0, 8'd3, 2};
    zero_tab[1] = '{8'd0, 8'd5, 8'd1, 2};
    zero_tab[2] = '{8'd1, 8'd1, 8'd0, 2};

    // Reset values
    rst = 1'b0;
    tick();
    tick();
    chk("rst start_ready", start_ready, 1);
    chk("rst issue_valid", issue_valid, 0);
    chk("rst indices", {issue_row, issue_red, issue_col}, 0);
    chk("rst first/last", {issue_first, issue_last}, 0);
    chk("rst done/busy/err", {done_valid, busy, err_retire}, 0);
    chk("rst perf", perf_cycles | perf_stalls, 0);
    chk("retire_ready", retire_ready, 1);
    rst = 1'b1;
    tick();

    // Basic 2x3x2 job, retire 3 cycles after each issue
    issue_ready = 1'b1;
    auto_ret = 1'b1;
    mon_en = 1'b1;
    start_job(8'd2, 8'd3, 8'd2);
    chk("basic issue_valid 1 cycle after start", issue_valid, 1);
    chk("basic busy/start_ready", {busy, start_ready}, 2'b10);
    wait_done("basic", 300);
    ack_done();
    chk("basic start_ready after done", start_ready, 1);
    cmp_seq("basic", basic_tab, 12);
    chk("basic done count", n_done, 1);
    chk("basic retires before done", ret_at_done, 12);
    chk("basic err_retire", err_retire, 0);
`ifdef MATMUL_SCHED_PERF_EN
    chk("basic perf_cycles nonzero", perf_cycles != 0, 1);
`else
    chk("basic perf tied off", perf_cycles | perf_stalls, 0);
`endif
    mon_en = 1'b0;
    auto_ret = 1'b0;
    tick();

    // Credit limit: single tile, then 1x4x1 with retires withheld
    start_job(8'd1, 8'd1, 8'd1);
    chk("1x1x1 issue_valid", issue_valid, 1);
    tick();
    chk("1x1x1 waits for retire", {issue_valid, done_valid, busy}, 3'b001);
    retire_one();
    chk("1x1x1 done after retire", done_valid, 1);
    ack_done();
    start_job(8'd1, 8'd4, 8'd1);
    tick();
    tick();
    chk("credit valid drops after 2 issues", issue_valid, 0);
    tick();
    tick();
    chk("credit still stalled", {issue_valid, issue_red}, {1'b0, 8'd2});
    retire_one();
    chk("credit released one", {issue_valid, issue_red}, {1'b1, 8'd2});
    tick();
    chk("credit stalled again", {issue_valid, issue_red, issue_last}, {1'b0, 8'd3, 1'b1});
`ifdef MATMUL_SCHED_PERF_EN
    chk("credit perf_stalls nonzero", perf_stalls != 0, 1);
`endif
    retire_one();
    tick();
    chk("credit last issued -> drain", {issue_valid, busy, done_valid}, 3'b010);
    retire_one();
    chk("credit drain not done at 1 left", done_valid, 0);
    retire_one();
    chk("credit done", done_valid, 1);
    ack_done();

    // Backpressure, simultaneous issue+retire, done backpressure
    issue_ready = 1'b0;
    start_job(8'd1, 8'd4, 8'd1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp cycle %0d stable", i), {issue_valid, issue_row, issue_red, issue_col, issue_first},
          {1'b1, 8'd0, 8'd0, 8'd0, 1'b1});
      tick();
    end
    issue_ready = 1'b1;
    tick();
    man_retire = 1'b1;
    tick();
    man_retire = 1'b0;
    chk("simul issue+retire keeps credit", {issue_valid, issue_red}, {1'b1, 8'd2});
    tick();
    chk("simul then credit full", issue_valid, 0);
    retire_one();
    tick();
    retire_one();
    retire_one();
    chk("bp job done", done_valid, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("done bp cycle %0d", i), {done_valid, start_ready}, 2'b10);
    end
    ack_done();
    chk("done hs -> idle", {start_ready, done_valid, busy}, 3'b100);

    // Zero dimensions
    foreach (zero_tab[i]) begin
      int c;
      start_job(zero_tab[i].n, zero_tab[i].m, zero_tab[i].k);
      c = 0;
      while (!done_valid && c < zero_tab[i].max_done_wait) begin
        chk($sformatf("zero %0d no issue", i), issue_valid, 0);
        tick();
        c++;
      end
      chk($sformatf("zero %0d done/busy/no issue", i), {done_valid, busy, issue_valid}, 3'b110);
      tick();
      chk($sformatf("zero %0d busy held", i), {done_valid, busy}, 2'b11);
      ack_done();
      chk($sformatf("zero %0d idle", i), {busy, start_ready}, 2'b01);
    end

    // Spurious retire, then reset mid-ISSUE
    retire_one();
    chk("err set", err_retire, 1);
    start_job(8'd2, 8'd2, 8'd2);
    tick();
    tick();
    chk("err sticky mid-job", {err_retire, busy}, 2'b11);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("reset aborts job", {issue_valid, err_retire, busy, start_ready}, 4'b0001);
    chk("reset clears indices", {issue_row, issue_red, issue_col}, 0);
    tick();
    iss_q.delete();
    n_ret = 0;
    n_done = 0;
    ret_at_done = -1;
    auto_ret = 1'b1;
    mon_en = 1'b1;
    start_job(8'd1, 8'd2, 8'd1);
    wait_done("post-reset", 100);
    ack_done();
    cmp_seq("post-reset", small_tab, 2);
    chk("post-reset retires before done", ret_at_done, 2);
    chk("post-reset err clear", err_retire, 0);
    mon_en = 1'b0;
    auto_ret = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end
endmodule
